sram_bist_ctrl: RTL and testbench

Built-in self-test initiator for the team's 32×4 synchronous single-port SRAM. It drives the memory's `we`/`addr`/`din` pins and checks `dout`. On a `start` request it runs a four-phase march: write a pattern, read and compare, write the inverse, read and compare. It then reports pass/fail with the first failing address and the data read there. The block sits beside the SRAM and owns its port during a test.

---
 rtl/sram_bist_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_sram_bist_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_ctrl.sv
// ============================================================================
// sram_bist_ctrl
// ----------------------------------------------------------------------------
// Built-in self-test initiator for a small synchronous single-port SRAM.
// While a test runs, this block owns the SRAM port and performs a four-phase
// march:
//   WR0 : write P(a)  = a ^ PATTERN to every address, ascending
//   RD0 : read back every address and compare against P(a)
//   WR1 : write ~P(a) to every address, ascending
//   RD1 : read back every address and compare against ~P(a)
// The first mismatch ends the test early. The block then reports the failing
// address and the data that was read there.
//
// Parameters
//   AW       address width, depth is 2**AW
//   DW       data width
//   RD_LAT   SRAM read latency in rising edges (1..3)
//   PATTERN  XOR seed applied to the low DW address bits to form write data
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset; aborts a running test at once
//   start      test request, honoured only while idle or done
//   mem_we     SRAM write enable
//   mem_addr   SRAM address
//   mem_din    SRAM write data
//   mem_dout   SRAM read data, valid RD_LAT edges after the read address
//   busy       high while a test runs
//   done       high from test end until the next start
//   pass       valid while done; 1 means no mismatch was seen
//   fail_addr  first failing address (0 on pass)
//   fail_data  data read at fail_addr (0 on pass)
// ============================================================================
module sram_bist_ctrl #(
    parameter int              AW      = 5,
    parameter int              DW      = 4,
    parameter int              RD_LAT  = 1,
    parameter logic [DW-1:0]   PATTERN = 4'hA
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        WR1,
        RD1,
        DONE
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    // Write data for address a. The inverted phases use the bitwise
    // complement, so every cell is exercised with both polarities.
    function automatic logic [DW-1:0] patternFor(input logic [AW-1:0] addr,
                                                 input logic          inv);
        logic [DW-1:0] p;
        p = DW'(addr) ^ PATTERN;
        return inv ? ~p : p;
    endfunction

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    state_e          state_q;
    logic            memWe_q;
    logic [AW-1:0]   memAddr_q;
    logic [DW-1:0]   memDin_q;
    logic            issuing_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [AW-1:0]   failAddr_q;
    logic [DW-1:0]   failData_q;

    // Read tracking pipeline: one entry per issued read, head at RD_LAT-1.
    logic            pipeValid_q [RD_LAT];
    logic [AW-1:0]   pipeAddr_q  [RD_LAT];
    logic [DW-1:0]   pipeExp_q   [RD_LAT];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic            inRead_d;
    logic            invPhase_d;
    logic [AW-1:0]   nextAddr_d;
    logic [DW-1:0]   issueExp_d;
    logic            headValid_d;
    logic            headMismatch_d;
    logic            headLast_d;
    logic            flush_d;
    logic            loadValid_d;

    // The head entry lines up with mem_dout for the read it describes, so the
    // compare is purely combinational. A mismatch or the final compare of a
    // phase flushes the pipeline, which discards any reads still in flight.
    always_comb begin
        inRead_d       = (state_q == RD0) || (state_q == RD1);
        invPhase_d     = (state_q == WR1) || (state_q == RD1);
        nextAddr_d     = memAddr_q + AW'(1);
        issueExp_d     = patternFor(memAddr_q, invPhase_d);
        headValid_d    = inRead_d && pipeValid_q[RD_LAT-1];
        headMismatch_d = headValid_d && (mem_dout != pipeExp_q[RD_LAT-1]);
        headLast_d     = headValid_d && (pipeAddr_q[RD_LAT-1] == LAST_ADDR);
        flush_d        = headMismatch_d || headLast_d;
        loadValid_d    = inRead_d && issuing_q && !flush_d;
    end

    // Shift register that follows each issued read. Stage 0 captures the
    // address and expected data in the cycle the read is presented; the entry
    // reaches the head exactly when the SRAM returns that read's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipeValid_q[i] <= 1'b0;
                pipeAddr_q[i]  <= '0;
                pipeExp_q[i]   <= '0;
            end
        end else begin
            pipeValid_q[0] <= loadValid_d;
            pipeAddr_q[0]  <= memAddr_q;
            pipeExp_q[0]   <= issueExp_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1] && !flush_d;
                pipeAddr_q[i]  <= pipeAddr_q[i-1];
                pipeExp_q[i]   <= pipeExp_q[i-1];
            end
        end
    end

    // Test sequencer. All SRAM port values and status outputs are registered
    // here so they change only on clock edges (or immediately on reset).
    // During the drain part of a read phase issuing_q is low and the address
    // holds at the last location until the final compare retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memDin_q   <= '0;
            issuing_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failAddr_q <= '0;
            failData_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= WR0;
                        memWe_q    <= 1'b1;
                        memAddr_q  <= '0;
                        memDin_q   <= patternFor('0, 1'b0);
                        issuing_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        failAddr_q <= '0;
                        failData_q <= '0;
                    end
                end

                WR0, WR1: begin
                    if (memAddr_q == LAST_ADDR) begin
                        // The address wraps to 0 only at this phase change.
                        state_q   <= (state_q == WR0) ? RD0 : RD1;
                        memWe_q   <= 1'b0;
                        memAddr_q <= '0;
                        memDin_q  <= '0;
                        issuing_q <= 1'b1;
                    end else begin
                        memAddr_q <= nextAddr_d;
                        memDin_q  <= patternFor(nextAddr_d, invPhase_d);
                    end
                end

                RD0, RD1: begin
                    if (headMismatch_d) begin
                        state_q    <= DONE;
                        memWe_q    <= 1'b0;
                        memAddr_q  <= '0;
                        memDin_q   <= '0;
                        issuing_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        failAddr_q <= pipeAddr_q[RD_LAT-1];
                        failData_q <= mem_dout;
                    end else if (headLast_d) begin
                        issuing_q <= 1'b0;
                        if (state_q == RD0) begin
                            // First inverted write follows the last RD0
                            // compare with no gap.
                            state_q   <= WR1;
                            memWe_q   <= 1'b1;
                            memAddr_q <= '0;
                            memDin_q  <= patternFor('0, 1'b1);
                        end else begin
                            state_q    <= DONE;
                            memWe_q    <= 1'b0;
                            memAddr_q  <= '0;
                            memDin_q   <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            pass_q     <= 1'b1;
                            failAddr_q <= '0;
                            failData_q <= '0;
                        end
                    end else if (issuing_q) begin
                        if (memAddr_q == LAST_ADDR) begin
                            issuing_q <= 1'b0;
                        end else begin
                            memAddr_q <= nextAddr_d;
                        end
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    memWe_q   <= 1'b0;
                    memAddr_q <= '0;
                    memDin_q  <= '0;
                    issuing_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_din   = memDin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = failAddr_q;
    assign fail_data = failData_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// ============================================================================
// tb_sram_bist_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for sram_bist_ctrl. Two controllers are instantiated,
// one with a 1-cycle SRAM and one with a 2-cycle SRAM. Each SRAM model can be
// given read faults (bits forced to 0 on readback) and write faults (bits
// that fail to store 1, separately for the true and the inverted pattern).
// The expected outcome of every run comes from a march model that walks the
// four phases over a plain array and derives the result and run length.
// ============================================================================
module tb_sram_bist_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   logic       startSig [2];
   logic       memWe    [2];
   logic [4:0] memAddr  [2];
   logic [3:0] memDin   [2];
   logic [3:0] memDout  [2];
   logic       busy     [2];
   logic       done     [2];
   logic       pass     [2];
   logic [4:0] failAddr [2];
   logic [3:0] failData [2];

   logic [3:0] rdMask  [32];
   logic [3:0] wr0Mask [32];
   logic [3:0] wr1Mask [32];

   logic [3:0] memArr [2][32];
   logic [3:0] rdPipe [2][2];

   int runId   [2];
   int seenRun [2];
   int busyCnt [2];
   int weCnt   [2];
   int portErr [2];

   int total;
   int bad;

   always #5 clk = ~clk;

   sram_bist_ctrl #(.AW(5), .DW(4), .RD_LAT(1), .PATTERN(4'hA)) dutLat1 (
      .clk(clk), .rst_n(rst_n), .start(startSig[0]),
      .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_din(memDin[0]),
      .mem_dout(memDout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .fail_addr(failAddr[0]), .fail_data(failData[0])
   );

   sram_bist_ctrl #(.AW(5), .DW(4), .RD_LAT(2), .PATTERN(4'hA)) dutLat2 (
      .clk(clk), .rst_n(rst_n), .start(startSig[1]),
      .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_din(memDin[1]),
      .mem_dout(memDout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .fail_addr(failAddr[1]), .fail_data(failData[1])
   );

   assign memDout[0] = rdPipe[0][0];
   assign memDout[1] = rdPipe[1][1];

   function automatic logic [3:0] pat(input int a, input int inv);
      logic [3:0] p;
      p = a[3:0] ^ 4'hA;
      return (inv != 0) ? ~p : p;
   endfunction

   // Write faults depend on which polarity is being stored in the cell.
   function automatic logic [3:0] wrMaskFor(input logic [4:0] a, input logic [3:0] d);
      if (d == pat(int'(a), 0)) return wr0Mask[a];
      if (d == pat(int'(a), 1)) return wr1Mask[a];
      return 4'h0;
   endfunction

   // A cycle is bad if a write is out of march order, if the port is not
   // parked at zero outside a test, or if busy and done overlap.
   function automatic bit portBad(input int k);
      bit wrBad;
      bit idleBad;
      wrBad   = memWe[k] && ((memAddr[k] !== 5'(weCnt[k] % 32)) ||
                (memDin[k] !== pat(weCnt[k] % 32, (weCnt[k] >= 32) ? 1 : 0)));
      idleBad = !busy[k] && (memWe[k] || memAddr[k] != 5'd0 || memDin[k] != 4'd0);
      return wrBad || idleBad || (busy[k] && done[k]);
   endfunction

   function automatic logic [31:0] outVec(input int k);
      return {10'd0, memWe[k], memAddr[k], memDin[k], busy[k], done[k], pass[k],
              failAddr[k], failData[k]};
   endfunction

   // SRAM models plus per-run bookkeeping, looking at the values present
   // just before each rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (runId[k] != seenRun[k]) begin
            seenRun[k] <= runId[k];
            busyCnt[k] <= 0;
            weCnt[k]   <= 0;
            portErr[k] <= 0;
         end else begin
            if (busy[k]) busyCnt[k] <= busyCnt[k] + 1;
            if (memWe[k]) weCnt[k] <= weCnt[k] + 1;
            if (portBad(k)) portErr[k] <= portErr[k] + 1;
         end
         rdPipe[k][1] <= rdPipe[k][0];
         if (memWe[k])
            memArr[k][memAddr[k]] <= memDin[k] & ~wrMaskFor(memAddr[k], memDin[k]);
         else
            rdPipe[k][0] <= memArr[k][memAddr[k]] & ~rdMask[memAddr[k]];
      end
   end

   // March model: walk both polarities over a plain array and report the
   // first address whose readback differs, with the run length it implies.
   task automatic predict(input int lat, output logic ePass, output logic [4:0] eAddr,
                          output logic [3:0] eData, output int eCycles, output int eWrites);
      logic [3:0] stored [32];
      logic [3:0] rd;
      bit found;
      ePass = 1'b1; eAddr = 5'd0; eData = 4'd0;
      eCycles = 4 * 32 + 2 * lat; eWrites = 64; found = 0;
      for (int ph = 0; ph < 2 && !found; ph++) begin
         for (int a = 0; a < 32; a++)
            stored[a] = pat(a, ph) & ~((ph == 0) ? wr0Mask[a] : wr1Mask[a]);
         for (int a = 0; a < 32 && !found; a++) begin
            rd = stored[a] & ~rdMask[a];
            if (rd != pat(a, ph)) begin
               found   = 1;
               ePass   = 1'b0;
               eAddr   = 5'(a);
               eData   = rd;
               eCycles = ph * (2 * 32 + lat) + 32 + a + lat + 1;
               eWrites = (ph + 1) * 32;
            end
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clearFaults();
      for (int a = 0; a < 32; a++) begin
         rdMask[a]  = 4'h0;
         wr0Mask[a] = 4'h0;
         wr1Mask[a] = 4'h0;
      end
   endtask

   task automatic applyStimulus(input int k);
      @(negedge clk);
      runId[k]    = runId[k] + 1;
      startSig[k] = 1'b1;
      @(negedge clk);
      startSig[k] = 1'b0;
   endtask

   task automatic waitDone(input int k, input string tag);
      int n;
      n = 0;
      while (!done[k] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!done[k]) checkOutput($sformatf("%s.timeout", tag), 32'(done[k]), 1);
   endtask

   task automatic checkRun(input int k, input string tag);
      logic       ePass;
      logic [4:0] eAddr;
      logic [3:0] eData;
      int         eCycles;
      int         eWrites;
      predict(k + 1, ePass, eAddr, eData, eCycles, eWrites);
      checkOutput($sformatf("%s.done", tag), 32'(done[k]), 1);
      checkOutput($sformatf("%s.busy", tag), 32'(busy[k]), 0);
      checkOutput($sformatf("%s.pass", tag), 32'(pass[k]), 32'(ePass));
      checkOutput($sformatf("%s.failAddr", tag), 32'(failAddr[k]), 32'(eAddr));
      checkOutput($sformatf("%s.failData", tag), 32'(failData[k]), 32'(eData));
      checkOutput($sformatf("%s.cycles", tag), 32'(busyCnt[k]), 32'(eCycles));
      checkOutput($sformatf("%s.writes", tag), 32'(weCnt[k]), 32'(eWrites));
      checkOutput($sformatf("%s.portErr", tag), 32'(portErr[k]), 0);
   endtask

   initial begin
      int n;
      int k;
      int kind;
      int fa;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      startSig[0] = 1'b0;
      startSig[1] = 1'b0;
      runId[0] = 0;
      runId[1] = 0;
      clearFaults();

      // Reset values on both controllers.
      repeat (3) @(negedge clk);
      checkOutput("reset.lat1", outVec(0), 0);
      checkOutput("reset.lat2", outVec(1), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ideal SRAM, default latency.
      $display("[TB] ideal run, RD_LAT=1");
      applyStimulus(0);
      waitDone(0, "ideal");
      checkRun(0, "ideal");
      checkOutput("ideal.cycles130", 32'(busyCnt[0]), 130);
      checkOutput("ideal.we64", 32'(weCnt[0]), 64);

      // Read fault: dout[2] stuck at 0 at address 7, caught in RD0.
      $display("[TB] stuck bit at addr 7");
      rdMask[7] = 4'b0100;
      applyStimulus(0);
      waitDone(0, "stuck7");
      checkRun(0, "stuck7");
      checkOutput("stuck7.addr", 32'(failAddr[0]), 7);
      checkOutput("stuck7.data", 32'(failData[0]), 9);
      checkOutput("stuck7.noWr1", 32'(weCnt[0]), 32);
      clearFaults();

      // Write fault on the inverted pattern only, bit 0, addresses 16..31.
      $display("[TB] inverted-pattern fault above addr 15");
      for (int a = 16; a < 32; a++) wr1Mask[a] = 4'b0001;
      applyStimulus(0);
      waitDone(0, "inv16");
      checkRun(0, "inv16");
      checkOutput("inv16.addr", 32'(failAddr[0]), 16);
      checkOutput("inv16.data", 32'(failData[0]), 4);
      clearFaults();

      // Reset in the middle of WR1 at address 10.
      $display("[TB] reset during WR1");
      applyStimulus(0);
      n = 0;
      while (!(memWe[0] && memAddr[0] == 5'd10 && weCnt[0] >= 32) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midrst.writesSoFar", 32'(weCnt[0]), 42);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.outs", outVec(0), 0);
      repeat (3) @(negedge clk);
      checkOutput("midrst.noWrite", 32'(weCnt[0]), 42);
      checkOutput("midrst.outsHeld", outVec(0), 0);
      rst_n = 1'b1;
      applyStimulus(0);
      waitDone(0, "afterRst");
      checkRun(0, "afterRst");

      // Start held and re-pulsed while busy must not restart the test.
      $display("[TB] start held during busy");
      @(negedge clk);
      runId[0]    = runId[0] + 1;
      startSig[0] = 1'b1;
      repeat (40) @(negedge clk);
      startSig[0] = 1'b0;
      repeat (50) @(negedge clk);
      startSig[0] = 1'b1;
      @(negedge clk);
      startSig[0] = 1'b0;
      waitDone(0, "held");
      checkRun(0, "held");

      // Start while done clears the status on the next edge and reruns.
      $display("[TB] restart from done");
      @(negedge clk);
      runId[0]    = runId[0] + 1;
      startSig[0] = 1'b1;
      @(negedge clk);
      startSig[0] = 1'b0;
      checkOutput("restart.doneLow", 32'(done[0]), 0);
      checkOutput("restart.busyHigh", 32'(busy[0]), 1);
      checkOutput("restart.passClr", 32'(pass[0]), 0);
      waitDone(0, "restart");
      checkRun(0, "restart");

      // Two-cycle SRAM: clean run, then a fault seen during the RD0 drain.
      $display("[TB] RD_LAT=2 runs");
      applyStimulus(1);
      waitDone(1, "lat2");
      checkRun(1, "lat2");
      checkOutput("lat2.cycles132", 32'(busyCnt[1]), 132);
      rdMask[31] = 4'b0001;
      applyStimulus(1);
      waitDone(1, "lat2a31");
      checkRun(1, "lat2a31");
      checkOutput("lat2a31.addr", 32'(failAddr[1]), 31);
      clearFaults();

      // Random single faults on alternating controllers.
      $display("[TB] random fault runs");
      for (int r = 0; r < 10; r++) begin
         k    = r % 2;
         kind = $urandom_range(0, 3);
         fa   = $urandom_range(0, 31);
         clearFaults();
         case (kind)
            1: rdMask[fa]  = 4'($urandom_range(1, 15));
            2: wr0Mask[fa] = 4'($urandom_range(1, 15));
            3: wr1Mask[fa] = 4'($urandom_range(1, 15));
            default: ;
         endcase
         applyStimulus(k);
         waitDone(k, $sformatf("rand%0d", r));
         checkRun(k, $sformatf("rand%0d", r));
      end
      clearFaults();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
